// File: rtl/avalon_burst_master.sv
// Avalon-MM burst initiator: one burst at a time, burst writes fed from a
// valid/ready stream, burst reads returned on rd_data/rd_valid.
module avalon_burst_master #(
    parameter int unsigned MAX_BURST = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [12:0] cmd_address,
    input  logic [9:0]  cmd_burstcount,
    output logic        cmd_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        write,
    output logic        read,
    output logic        beginbursttransfer,
    output logic [9:0]  burstcount,
    output logic [12:0] address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    input  logic        waitrequest,
    input  logic [1:0]  response
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LOAD,
        WR_BEAT,
        RD_CMD,
        RD_DATA
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_cnt;
    logic [9:0]  w_cnt_inc;
    logic        w_cmd_bad;
    logic        w_wr_acc;
    logic        w_wr_last;
    logic        w_rd_beat;
    logic        w_rd_last;

    assign w_cmd_bad = (cmd_burstcount == '0) || (32'(cmd_burstcount) > MAX_BURST);
    assign w_cnt_inc = r_cnt + 10'd1;
    assign w_wr_acc  = (r_state == WR_BEAT) && write && !waitrequest;
    assign w_wr_last = w_wr_acc && (w_cnt_inc == burstcount);
    // A beat arriving in the same cycle the read command is accepted still counts.
    assign w_rd_beat = readdatavalid && ((r_state == RD_CMD) || (r_state == RD_DATA));
    assign w_rd_last = w_rd_beat && (w_cnt_inc == burstcount);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid && !w_cmd_bad) w_state_nxt = cmd_write ? WR_LOAD : RD_CMD;
            WR_LOAD: if (wr_valid) w_state_nxt = WR_BEAT;
            WR_BEAT: begin
                if (w_wr_last)                 w_state_nxt = IDLE;
                else if (w_wr_acc && !wr_valid) w_state_nxt = WR_LOAD;
            end
            RD_CMD: begin
                if (w_rd_last)         w_state_nxt = IDLE;
                else if (!waitrequest) w_state_nxt = RD_DATA;
            end
            RD_DATA: if (w_rd_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        wr_ready  = ((r_state == WR_LOAD) && !write) || (w_wr_acc && !w_wr_last);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write              <= 1'b0;
            read               <= 1'b0;
            beginbursttransfer <= 1'b0;
            rd_valid           <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            address            <= '0;
            burstcount         <= '0;
            writedata          <= '0;
            rd_data            <= '0;
            r_cnt              <= '0;
        end else begin
            done               <= 1'b0;
            rd_valid           <= 1'b0;
            beginbursttransfer <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (w_cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            address    <= cmd_address;
                            burstcount <= cmd_burstcount;
                            r_cnt      <= '0;
                            if (!cmd_write) begin
                                read               <= 1'b1;
                                beginbursttransfer <= 1'b1;
                            end
                        end
                    end
                end
                WR_LOAD: begin
                    if (wr_valid) begin
                        writedata          <= wr_data;
                        write              <= 1'b1;
                        beginbursttransfer <= (r_cnt == '0);
                    end
                end
                WR_BEAT: begin
                    if (w_wr_acc) begin
                        r_cnt <= w_cnt_inc;
                        if (w_wr_last) begin
                            write <= 1'b0;
                            done  <= 1'b1;
                        end else if (wr_valid) begin
                            writedata <= wr_data;
                        end else begin
                            write <= 1'b0;
                        end
                    end
                end
                RD_CMD, RD_DATA: begin
                    if ((r_state == RD_CMD) && !waitrequest) read <= 1'b0;
                    if (w_rd_beat) begin
                        rd_data  <= readdata;
                        rd_valid <= 1'b1;
                        r_cnt    <= w_cnt_inc;
                        if (response != 2'b00) err <= 1'b1;
                        if (w_rd_last) begin
                            done <= 1'b1;
                            read <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed bench for avalon_burst_master: a bus monitor pops expected write and
// read beats from scoreboard queues filled as the stimulus hands data over.
module tb_avalon_burst_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_write;
    logic [12:0] cmd_address;
    logic [9:0]  cmd_burstcount;
    logic        cmd_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        write;
    logic        read;
    logic        beginbursttransfer;
    logic [9:0]  burstcount;
    logic [12:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic [1:0]  response;

    avalon_burst_master #(.MAX_BURST(512)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_address(cmd_address),
        .cmd_burstcount(cmd_burstcount), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .write(write), .read(read), .beginbursttransfer(beginbursttransfer),
        .burstcount(burstcount), .address(address), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .response(response)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
    } rd_t;

    logic [31:0] wr_exp[$];
    rd_t         rd_exp[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_beat = 0;
    bit          mon_en = 0;
    bit          bbt_pending = 0;
    bit          hold_pend = 0;
    logic [31:0] hold_data = '0;
    logic [12:0] exp_addr = '0;
    logic [9:0]  exp_bc = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: scoreboard pops, burst-start marker, stall hold, done latency.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (write || read) begin
                check("bbt", 32'(beginbursttransfer), 32'(bbt_pending));
                bbt_pending = 0;
                check("address", 32'(address), 32'(exp_addr));
                check("burstcount", 32'(burstcount), 32'(exp_bc));
                check("no_overlap", 32'(write && read), 32'd0);
            end else begin
                check("bbt_idle", 32'(beginbursttransfer), 32'd0);
            end
            if (write && hold_pend) check("wdata_hold", writedata, hold_data);
            hold_pend = write && waitrequest;
            hold_data = writedata;
            if (write && !waitrequest) begin
                check("wr_q_nonempty", 32'(wr_exp.size() > 0), 32'd1);
                if (wr_exp.size() > 0) check("writedata", writedata, wr_exp.pop_front());
                last_beat = cyc;
            end
            if (rd_valid) begin
                check("rd_q_nonempty", 32'(rd_exp.size() > 0), 32'd1);
                if (rd_exp.size() > 0) begin
                    rd_t r;
                    r = rd_exp.pop_front();
                    check("rd_data", rd_data, r.d);
                    check("rd_lag", cyc, r.c + 1);
                end
                last_beat = cyc - 1;
            end
            if (done) begin
                done_cnt++;
                check("done_latency", cyc, last_beat + 1);
                check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_write", 32'(write), 32'd0);
        check("rst_read", 32'(read), 32'd0);
        check("rst_bbt", 32'(beginbursttransfer), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_burstcount", 32'(burstcount), 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Returns at the drive point of the cycle after the accepting edge.
    task automatic issue_cmd(input logic w, input logic [12:0] a, input logic [9:0] n);
        bit got = 0;
        cmd_valid      = 1'b1;
        cmd_write      = w;
        cmd_address    = a;
        cmd_burstcount = n;
        exp_addr       = a;
        exp_bc         = n;
        bbt_pending    = (n != 0) && (n <= 10'd512);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(got), 32'd1);
    endtask

    task automatic wr_phase(input int n, input logic [31:0] base, input int stall_beat,
                            input int stall_cyc, input int gap_beat, input int gap_cyc,
                            input int abort_at, output int wr_cyc, output int low_cyc,
                            output int first_off);
        int idx = 0;
        int acc = 0;
        int stall_left = stall_cyc;
        int gap_left = gap_cyc;
        int t0 = cyc;
        bit seen = 0;
        wr_cyc = 0;
        low_cyc = 0;
        first_off = -1;
        for (int it = 0; it < 100; it++) begin
            if (acc == abort_at) return;
            waitrequest = write && (acc == stall_beat) && (stall_left > 0);
            if (waitrequest) stall_left--;
            wr_valid = (idx < n) && !(idx == gap_beat && gap_left > 0);
            if (idx == gap_beat && gap_left > 0 && !waitrequest) gap_left--;
            wr_data = base + 32'(idx);
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                wr_exp.push_back(wr_data);
                idx++;
            end
            if (write) begin
                wr_cyc++;
                if (first_off < 0) first_off = cyc - t0;
            end else if (first_off >= 0 && !done) begin
                low_cyc++;
            end
            if (write && !waitrequest) acc++;
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
        waitrequest = 1'b0;
        tick();
        check("wr_done_seen", 32'(seen), 32'd1);
        check("wr_beats", acc, n);
        check("wr_q_empty", 32'(wr_exp.size()), 32'd0);
    endtask

    task automatic rd_phase(input int n, input logic [31:0] base, input int wait_cyc,
                            input int err_beat, output int rd_cyc);
        int sent = 0;
        int wait_left = wait_cyc;
        bit acc = 0;
        bit seen = 0;
        rd_t r;
        rd_cyc = 0;
        for (int it = 0; it < 200; it++) begin
            waitrequest = read && !acc && (wait_left > 0);
            if (waitrequest) wait_left--;
            if (acc && sent < n && (it % 3) != 1) begin
                readdatavalid = 1'b1;
                readdata      = base + 32'(sent);
                response      = (sent == err_beat) ? 2'b10 : 2'b00;
                r.d = readdata;
                r.c = cyc;
                rd_exp.push_back(r);
                sent++;
            end else begin
                readdatavalid = 1'b0;
                response      = 2'b00;
            end
            @(negedge clk);
            if (it == 0) check("read_at_k1", 32'(read), 32'd1);
            if (read) rd_cyc++;
            if (read && !waitrequest) acc = 1;
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        readdatavalid = 1'b0;
        response = 2'b00;
        waitrequest = 1'b0;
        tick();
        check("rd_done_seen", 32'(seen), 32'd1);
        check("rd_q_empty", 32'(rd_exp.size()), 32'd0);
    endtask

    initial begin
        int wc, lc, fo, rc, act;
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_burstcount = '0;
        wr_data = '0; wr_valid = 1'b0;
        readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0; response = 2'b00;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals();
        mon_en = 1;
        tick();

        // Plain 4-beat write
        issue_cmd(1'b1, 13'h010, 10'd4);
        check("w1_err", 32'(err), 32'd0);
        wr_phase(4, 32'hA0, 99, 0, 99, 0, 99, wc, lc, fo);
        check("w1_write_cycles", wc, 4);
        check("w1_write_gaps", lc, 0);
        check("w1_first_write_k2", fo, 1);

        // Write with a 3-cycle stall on beat 1 and a source gap before beat 2
        issue_cmd(1'b1, 13'h020, 10'd4);
        wr_phase(4, 32'hB0, 1, 3, 2, 2, 99, wc, lc, fo);
        check("w2_write_cycles", wc, 7);
        check("w2_write_dropped", 32'(lc > 0), 32'd1);

        // 8-beat read with 2 waitrequest cycles and gapped returns
        issue_cmd(1'b0, 13'h1000, 10'd8);
        rd_phase(8, 32'hC0DE0000, 2, 99, rc);
        check("r8_read_cycles", rc, 3);
        check("r8_err", 32'(err), 32'd0);

        // Error response on the first beat of a 2-beat read
        issue_cmd(1'b0, 13'h040, 10'd2);
        rd_phase(2, 32'h000000E0, 0, 0, rc);
        check("rerr_err_set", 32'(err), 32'd1);

        // Next valid command clears err
        issue_cmd(1'b1, 13'h044, 10'd1);
        check("err_cleared", 32'(err), 32'd0);
        wr_phase(1, 32'hF0, 99, 0, 99, 0, 99, wc, lc, fo);

        // Zero-length command
        issue_cmd(1'b0, 13'h048, 10'd0);
        check("bad0_err", 32'(err), 32'd1);
        check("bad0_cmd_ready", 32'(cmd_ready), 32'd1);
        act = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (write || read || wr_ready) act++;
            tick();
        end
        check("bad0_no_bus", act, 0);

        // Reset while beat 2 of a 4-beat write is on the bus
        issue_cmd(1'b1, 13'h050, 10'd4);
        wr_phase(4, 32'hD0, 99, 0, 99, 0, 1, wc, lc, fo);
        check("rst_mid_write_high", 32'(write), 32'd1);
        reset_n = 1'b0;
        wr_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        wr_exp.delete();
        hold_pend = 0;
        bbt_pending = 0;
        @(negedge clk);
        check_reset_vals();
        tick();

        // Over-length command
        issue_cmd(1'b0, 13'h000, 10'd600);
        check("over_err", 32'(err), 32'd1);

        // Single-beat read after the abort
        issue_cmd(1'b0, 13'h060, 10'd1);
        rd_phase(1, 32'h12345678, 0, 99, rc);
        check("r1_err", 32'(err), 32'd0);

        // Back-to-back: read command held pending while a 1-beat write finishes
        issue_cmd(1'b1, 13'h068, 10'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 13'h070;
        cmd_burstcount = 10'd1;
        wr_phase(1, 32'h55AA0000, 99, 0, 99, 0, 99, wc, lc, fo);
        exp_addr = 13'h070;
        exp_bc = 10'd1;
        bbt_pending = 1;
        cmd_valid = 1'b0;
        rd_phase(1, 32'h77770000, 0, 99, rc);

        check("done_total", done_cnt, 8);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
